// File: rtl/wb_sram_slave.sv
// Wishbone classic slave driving one asynchronous 32-bit SRAM bank.
// Each single access becomes a fixed-timing SRAM cycle with one ack.
module wb_sram_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic                         wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  input  logic                         wb_we_i,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
  output logic                         sram_data_t,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BW = SRAM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_SAMPLE = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t state, state_d;

  logic                       ack_d;
  logic [DATA_WIDTH-1:0]      dat_o_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_d;
  logic [SRAM_DATA_WIDTH-1:0] data_o_d;
  logic                       data_t_d;
  logic                       ce_d;
  logic                       oe_d;
  logic                       we_d;
  logic [BW-1:0]              be_d;

  // Byte-lane bits and bits above the bank are not decoded here.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2],
                        wb_adr_i[1:0]};

  always_comb begin
    state_d  = state;
    ack_d    = wb_ack_o;
    dat_o_d  = wb_dat_o;
    addr_d   = sram_addr;
    data_o_d = sram_data_o;
    data_t_d = sram_data_t;
    ce_d     = sram_ce_n;
    oe_d     = sram_oe_n;
    we_d     = sram_we_n;
    be_d     = sram_be_n;
    unique case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
          ce_d   = 1'b0;
          if (wb_we_i) begin
            state_d  = WR_SETUP;
            data_t_d = 1'b0;
            data_o_d = wb_dat_i;
            we_d     = 1'b1;
            be_d     = ~wb_sel_i;
          end else begin
            state_d = RD_SETUP;
            oe_d    = 1'b0;
            be_d    = '0;
          end
        end
      end
      RD_SETUP: state_d = RD_SAMPLE;
      RD_SAMPLE: begin
        dat_o_d = sram_data_i;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        ack_d   = wb_cyc_i;
        state_d = DONE;
      end
      WR_SETUP: begin
        we_d    = 1'b0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        we_d    = 1'b1;
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        ce_d     = 1'b1;
        data_t_d = 1'b1;
        ack_d    = wb_cyc_i;
        state_d  = DONE;
      end
      // Ack cycle: a still-high strobe must not restart.
      DONE: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      sram_addr   <= '0;
      sram_data_o <= '0;
      sram_data_t <= 1'b1;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= '1;
    end else begin
      state       <= state_d;
      wb_ack_o    <= ack_d;
      wb_dat_o    <= dat_o_d;
      sram_addr   <= addr_d;
      sram_data_o <= data_o_d;
      sram_data_t <= data_t_d;
      sram_ce_n   <= ce_d;
      sram_oe_n   <= oe_d;
      sram_we_n   <= we_d;
      sram_be_n   <= be_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave with a behavioural async SRAM.
// Cycle 0 is the cycle stb is raised; outputs sampled 1ns after each edge.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_i;
  logic [31:0] sram_data_o;
  logic        sram_data_t;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:4095];
  logic        ack_prev = 1'b0;

  always #5 clk = ~clk;

  wb_sram_slave dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_ack_o   (ack),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_dat_o   (rdat),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .sram_addr  (sram_addr),
    .sram_data_i(sram_data_i),
    .sram_data_o(sram_data_o),
    .sram_data_t(sram_data_t),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n)
  );

  // Async SRAM: reads while ce/oe low, byte writes while we_n low.
  always_comb begin
    sram_data_i = 32'h0BAD_0BAD;
    if (!sram_ce_n && !sram_oe_n)
      sram_data_i = mem[sram_addr[11:0]];
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && !sram_data_t) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          mem[sram_addr[11:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  // Every-cycle protocol invariants.
  always @(negedge clk) begin
    if (!rst) begin
      tests += 3;
      if (!sram_oe_n && !sram_we_n) begin
        fails++;
        $display("FAIL inv_oe_we oe_n=0 we_n=0 at %0t", $time);
      end
      if (ack && ack_prev) begin
        fails++;
        $display("FAIL inv_ack_width ack high 2 cycles at %0t", $time);
      end
      if (!sram_data_t && !(3'(dut.state) inside {3'd3, 3'd4, 3'd5})) begin
        fails++;
        $display("FAIL inv_data_t state=%0d data_t=0 at %0t",
                 3'(dut.state), $time);
      end
    end
    ack_prev = ack;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    tick();
    tick();
  endtask

  // Bus read; result compared by the caller.
  task automatic bus_read(input logic [31:0] a,
                          output logic [31:0] d,
                          output int n);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = a;
    sel = 4'hF;
    n   = 0;
    d   = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack) begin
        n++;
        d   = rdat;
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    bus_idle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick(); tick();
    tests += 6;
    if (ack !== 1'b0 || rdat !== 32'h0) begin
      fails++;
      $display("FAIL reset_wb ack=%b dat=%h want 0/0", ack, rdat);
    end
    if (sram_addr !== 20'h0 || sram_data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr addr=%h do=%h want 0", sram_addr, sram_data_o);
    end
    if (sram_data_t !== 1'b1) begin
      fails++;
      $display("FAIL reset_data_t got %b want 1", sram_data_t);
    end
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ctl ce/oe/we=%b want 111",
               {sram_ce_n, sram_oe_n, sram_we_n});
    end
    if (sram_be_n !== 4'hF) begin
      fails++;
      $display("FAIL reset_be got %b want 1111", sram_be_n);
    end
    if (3'(dut.state) !== 3'd0) begin
      fails++;
      $display("FAIL reset_state got %0d want 0", 3'(dut.state));
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read;
    logic low;
    mem[12'h010] = 32'hDEAD_BEEF;
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = 32'h8000_0040;
    sel = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      low = (k == 1 || k == 2);
      tests += 2;
      if (sram_ce_n !== !low || sram_oe_n !== !low) begin
        fails++;
        $display("FAIL read_ce_oe cyc%0d ce_n=%b oe_n=%b want %b",
                 k, sram_ce_n, sram_oe_n, !low);
      end
      if (ack !== (k == 3)) begin
        fails++;
        $display("FAIL read_ack cyc%0d got %b want %b", k, ack, k == 3);
      end
      if (k == 1) begin
        tests += 2;
        if (sram_addr !== 20'h00010) begin
          fails++;
          $display("FAIL read_addr got %h want 00010", sram_addr);
        end
        if (sram_be_n !== 4'h0) begin
          fails++;
          $display("FAIL read_be got %b want 0000", sram_be_n);
        end
      end
      if (k == 3) begin
        tests++;
        if (rdat !== 32'hDEAD_BEEF) begin
          fails++;
          $display("FAIL read_data got %h want deadbeef", rdat);
        end
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    bus_idle();
  endtask

  task automatic test_write;
    logic [31:0] d;
    int n;
    mem[12'h040] = 32'h1122_3344;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b1;
    adr  = 32'h8000_0103;
    sel  = 4'b0100;
    wdat = 32'h00AB_0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests += 4;
      if (sram_we_n !== (k != 2)) begin
        fails++;
        $display("FAIL write_we cyc%0d got %b want %b", k, sram_we_n, k != 2);
      end
      if (sram_data_t !== !(k <= 3)) begin
        fails++;
        $display("FAIL write_data_t cyc%0d got %b", k, sram_data_t);
      end
      if (sram_ce_n !== !(k <= 3)) begin
        fails++;
        $display("FAIL write_ce cyc%0d got %b", k, sram_ce_n);
      end
      if (ack !== (k == 4)) begin
        fails++;
        $display("FAIL write_ack cyc%0d got %b want %b", k, ack, k == 4);
      end
      if (k <= 3) begin
        tests++;
        if (sram_addr !== 20'h00040 || sram_be_n !== 4'b1011 ||
            sram_data_o !== 32'h00AB_0000) begin
          fails++;
          $display("FAIL write_bus cyc%0d addr=%h be=%b do=%h",
                   k, sram_addr, sram_be_n, sram_data_o);
        end
      end
      if (k == 4) begin
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    bus_read(32'h8000_0100, d, n);
    tests++;
    if (n != 1 || d !== 32'h11AB_3344) begin
      fails++;
      $display("FAIL write_readback acks=%0d got %h want 11ab3344", n, d);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [31:0] d;
    n    = 0;
    d    = '0;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b1;
    adr  = 32'h0000_0200;
    sel  = 4'hF;
    wdat = 32'hCAFE_F00D;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (ack) begin
        n++;
        tests++;
        if ((n == 1 && k != 4) || (n == 2 && k != 8) || n > 2) begin
          fails++;
          $display("FAIL b2b_ack_timing ack#%0d in cyc%0d", n, k);
        end
        if (n == 1)
          we = 1'b0;
        if (n == 2) begin
          d   = rdat;
          cyc = 1'b0;
          stb = 1'b0;
        end
      end
    end
    tests += 2;
    if (n != 2) begin
      fails++;
      $display("FAIL b2b_ack_count got %0d want 2", n);
    end
    if (d !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL b2b_data got %h want cafef00d", d);
    end
    bus_idle();
  endtask

  task automatic test_sel_zero;
    int n;
    logic [31:0] d;
    n    = 0;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b1;
    adr  = 32'h0000_0200;
    sel  = 4'h0;
    wdat = 32'h1234_5678;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) begin
        tests++;
        if (sram_we_n !== 1'b0 || sram_be_n !== 4'hF) begin
          fails++;
          $display("FAIL sel0_pulse we_n=%b be=%b want 0/1111",
                   sram_we_n, sram_be_n);
        end
      end
      if (ack) begin
        n++;
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL sel0_ack got %0d acks want 1", n);
    end
    bus_read(32'h0000_0200, d, n);
    tests++;
    if (d !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL sel0_unchanged got %h want cafef00d", d);
    end
  endtask

  task automatic test_top_addr;
    int n;
    mem[12'hFFF] = 32'h5A5A_5A5A;
    n   = 0;
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = 32'h003F_FFFC;
    tick();
    tests++;
    if (sram_addr !== 20'hFFFFF) begin
      fails++;
      $display("FAIL top_addr got %h want fffff", sram_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (ack) begin
        n++;
        tests++;
        if (rdat !== 32'h5A5A_5A5A) begin
          fails++;
          $display("FAIL top_data got %h want 5a5a5a5a", rdat);
        end
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL top_ack got %0d want 1", n);
    end
    bus_idle();
  endtask

  task automatic test_cyc_ignored;
    cyc = 1'b0;
    stb = 1'b1;
    we  = 1'b0;
    adr = 32'h0000_0040;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (sram_ce_n !== 1'b1 || ack !== 1'b0 || 3'(dut.state) !== 3'd0) begin
        fails++;
        $display("FAIL nocyc cyc%0d ce_n=%b ack=%b state=%0d",
                 k, sram_ce_n, ack, 3'(dut.state));
      end
    end
    bus_idle();
  endtask

  task automatic test_abort;
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = 32'h8000_0040;
    tick();
    cyc = 1'b0;
    stb = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      tests++;
      if (ack !== 1'b0) begin
        fails++;
        $display("FAIL abort_ack cyc%0d got 1 want 0", k);
      end
      if (k == 2) begin
        tests++;
        if (sram_ce_n !== 1'b0 || sram_oe_n !== 1'b0) begin
          fails++;
          $display("FAIL abort_sram ce_n=%b oe_n=%b want 0/0",
                   sram_ce_n, sram_oe_n);
        end
      end
      if (k == 3) begin
        tests++;
        if (rdat !== 32'hDEAD_BEEF) begin
          fails++;
          $display("FAIL abort_sample got %h want deadbeef", rdat);
        end
      end
      if (k == 4) begin
        tests++;
        if (3'(dut.state) !== 3'd0) begin
          fails++;
          $display("FAIL abort_idle state=%0d want 0", 3'(dut.state));
        end
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b1;
    adr  = 32'h0000_0100;
    sel  = 4'hF;
    wdat = 32'hFFFF_FFFF;
    tick();
    tick();
    tests++;
    if (sram_we_n !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pulse we_n=%b want 0", sram_we_n);
    end
    rst = 1'b1;
    tick();
    tests += 3;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_data_t} !== 4'b1111) begin
      fails++;
      $display("FAIL rstmid_ctl ce/oe/we/t=%b want 1111",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_data_t});
    end
    if (sram_addr !== 20'h0 || sram_data_o !== 32'h0 ||
        sram_be_n !== 4'hF || rdat !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_regs addr=%h do=%h be=%b dat=%h",
               sram_addr, sram_data_o, sram_be_n, rdat);
    end
    if (ack !== 1'b0 || 3'(dut.state) !== 3'd0) begin
      fails++;
      $display("FAIL rstmid_state ack=%b state=%0d want 0/0",
               ack, 3'(dut.state));
    end
    rst = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (ack !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_noack ack=1 after reset, step %0d", k);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_sel_zero();
    test_top_addr();
    test_cyc_ignored();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
